// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: instruction-memory server states and the canonical NOP
// (addi x0, x0, 0).
package rv32i;

   typedef enum logic [1:0] {
      IMEM_IDLE = 2'd0,
      IMEM_LOAD = 2'd1,
      IMEM_RUN  = 2'd2
   } imem_state_e;

   localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_bram.sv
// Single-clock program BRAM: byte-enabled write port plus a registered read port.
// The memory array has no reset, so the program image survives a block reset.
module imem_bram #(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    be,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // The output register holds while re is low, so the fetched word stays stable.
   always_ff @(posedge clk) begin
      if (!reset_n)  rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: loads a program image from the bridge, then serves
// core fetches with one-cycle latency while holding the core in reset during loads.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IMEM_IDLE | after reset; core held in reset, fetches ignored
// IMEM_LOAD | accepting image writes; core held in reset and stalled
// IMEM_RUN  | core released; fetches served from the BRAM
module imem_server
   import rv32i::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load_start,
   input  logic        load_end,
   input  logic        load_we,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic [3:0]  load_be,
   input  logic [31:0] rom_addr,
   input  logic        rom_re,
   output logic [31:0] instr,
   output logic        rom_oe,
   output logic        stall,
   output logic        core_reset_n,
   output logic [15:0] loaded_words,
   output logic        fault
);

   localparam int AW = $clog2(DEPTH_WORDS);

   imem_state_e state, state_n;

   logic [31:0] load_off, rom_off;
   logic        load_ok, rom_ok;
   logic        wr_ok, fetch;
   logic        bad_q;
   logic [31:0] bram_q;

   // BASE_ADDR is word-aligned, so offset[1:0] equals addr[1:0].
   assign load_off = load_addr - BASE_ADDR;
   assign rom_off  = rom_addr  - BASE_ADDR;
   assign load_ok  = (load_off[1:0] == 2'b00) && (load_off[31:AW+2] == '0);
   assign rom_ok   = (rom_off[1:0]  == 2'b00) && (rom_off[31:AW+2]  == '0);

   assign wr_ok = (state == IMEM_LOAD) && load_we && load_ok;
   assign fetch = (state == IMEM_RUN) && rom_re && !load_start;

   always_comb begin
      state_n = state;
      case (state)
         IMEM_IDLE: if (load_start) state_n = IMEM_LOAD;
         IMEM_LOAD: if (!load_start && load_end) state_n = IMEM_RUN;
         IMEM_RUN:  if (load_start) state_n = IMEM_LOAD;
         default:   state_n = IMEM_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IMEM_IDLE;
         rom_oe       <= 1'b0;
         bad_q        <= 1'b0;
         stall        <= 1'b1;
         core_reset_n <= 1'b0;
         loaded_words <= '0;
         fault        <= 1'b0;
      end else begin
         state        <= state_n;
         rom_oe       <= fetch;
         stall        <= (state_n != IMEM_RUN);
         core_reset_n <= (state_n == IMEM_RUN);
         if (fetch) bad_q <= !rom_ok;

         if (load_start)                           loaded_words <= '0;
         else if (wr_ok && loaded_words != 16'hFFFF) loaded_words <= loaded_words + 16'd1;

         if (load_start)            fault <= 1'b0;
         else if (fetch && !rom_ok) fault <= 1'b1;
      end
   end

   imem_bram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_bram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_ok),
      .waddr   (load_off[AW+1:2]),
      .wdata   (load_data),
      .be      (load_be),
      .re      (fetch && rom_ok),
      .raddr   (rom_off[AW+1:2]),
      .rdata   (bram_q)
   );

   // Both bad_q and the BRAM output hold between fetches, so instr holds too.
   assign instr = bad_q ? RV32I_NOP : bram_q;

endmodule

// File: tb/tb_imem_server.sv
// Directed bench for imem_server: load, fetch, range faults, byte enables, reload.
module tb_imem_server;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_start, load_end, load_we;
   logic [31:0] load_addr, load_data;
   logic [3:0]  load_be;
   logic [31:0] rom_addr;
   logic        rom_re;
   logic [31:0] instr;
   logic        rom_oe, stall, core_reset_n, fault;
   logic [15:0] loaded_words;

   int total = 0;
   int bad   = 0;

   imem_server #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h8000_0000)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_start   (load_start),
      .load_end     (load_end),
      .load_we      (load_we),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .load_be      (load_be),
      .rom_addr     (rom_addr),
      .rom_re       (rom_re),
      .instr        (instr),
      .rom_oe       (rom_oe),
      .stall        (stall),
      .core_reset_n (core_reset_n),
      .loaded_words (loaded_words),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      load_we = 1'b1; load_addr = a; load_data = d; load_be = be;
      step();
      load_we = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      rom_re = 1'b1; rom_addr = a;
      step();
      rom_re = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; load_start = 1'b0; load_end = 1'b0; load_we = 1'b0;
      load_addr = '0; load_data = '0; load_be = 4'hF; rom_addr = '0; rom_re = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
      chk("rst_instr", instr, 32'h0);
      chk("rst_oe", {31'b0, rom_oe}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd1);
      chk("rst_core_rst", {31'b0, core_reset_n}, 32'd0);
      chk("rst_loaded", {16'b0, loaded_words}, 32'd0);
      chk("rst_fault", {31'b0, fault}, 32'd0);

      // Fetch in IDLE is ignored
      fetch(32'h8000_0000);
      chk("idle_fetch_oe", {31'b0, rom_oe}, 32'd0);

      load_start = 1'b1; step(); load_start = 1'b0;
      wr(32'h8000_0000, 32'h0010_0093, 4'hF);
      wr(32'h8000_0004, 32'h0020_0113, 4'hF);
      wr(32'h8000_0008, 32'h0020_81B3, 4'hF);
      chk("load3_count", {16'b0, loaded_words}, 32'd3);
      chk("load_stall", {31'b0, stall}, 32'd1);

      load_end = 1'b1; step(); load_end = 1'b0;
      chk("end_stall", {31'b0, stall}, 32'd0);
      chk("end_core_rst", {31'b0, core_reset_n}, 32'd1);
      chk("end_count", {16'b0, loaded_words}, 32'd3);

      fetch(32'h8000_0004);
      chk("f1_instr", instr, 32'h0020_0113);
      chk("f1_oe", {31'b0, rom_oe}, 32'd1);
      chk("f1_fault", {31'b0, fault}, 32'd0);
      step();
      chk("idle_oe", {31'b0, rom_oe}, 32'd0);
      chk("hold_instr", instr, 32'h0020_0113);

      fetch(32'h8000_4000);
      chk("oor_instr", instr, 32'h0000_0013);
      chk("oor_fault", {31'b0, fault}, 32'd1);
      fetch(32'h8000_0008);
      chk("f2_instr", instr, 32'h0020_81B3);
      chk("sticky_fault", {31'b0, fault}, 32'd1);
      fetch(32'h8000_0002);
      chk("mis_instr", instr, 32'h0000_0013);
      chk("mis_oe", {31'b0, rom_oe}, 32'd1);
      chk("mis_fault", {31'b0, fault}, 32'd1);

      // Reload mid-run with start and end together; start wins
      rom_re = 1'b1; rom_addr = 32'h8000_0000;
      load_start = 1'b1; load_end = 1'b1;
      step();
      load_start = 1'b0; load_end = 1'b0; rom_re = 1'b0;
      chk("rel_stall", {31'b0, stall}, 32'd1);
      chk("rel_core_rst", {31'b0, core_reset_n}, 32'd0);
      chk("rel_oe", {31'b0, rom_oe}, 32'd0);
      chk("rel_count", {16'b0, loaded_words}, 32'd0);
      chk("rel_fault", {31'b0, fault}, 32'd0);

      wr(32'h8000_0000, 32'hAABB_CCDD, 4'b0010);
      chk("be_count", {16'b0, loaded_words}, 32'd1);
      wr(32'h7FFF_FFFC, 32'hDEAD_BEEF, 4'hF);
      wr(32'h8000_0001, 32'hDEAD_BEEF, 4'hF);
      wr(32'h8000_4000, 32'hDEAD_BEEF, 4'hF);
      chk("drop_count", {16'b0, loaded_words}, 32'd1);

      // Write coincident with load_end is committed
      load_end = 1'b1;
      wr(32'h8000_000C, 32'h1234_5678, 4'hF);
      load_end = 1'b0;
      chk("end_wr_count", {16'b0, loaded_words}, 32'd2);
      chk("run2_stall", {31'b0, stall}, 32'd0);

      wr(32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
      chk("run_wr_count", {16'b0, loaded_words}, 32'd2);

      fetch(32'h8000_0000);
      chk("be_instr", instr, 32'h0010_CC93);
      fetch(32'h8000_000C);
      chk("endwr_instr", instr, 32'h1234_5678);
      fetch(32'h7FFF_FFFC);
      chk("below_instr", instr, 32'h0000_0013);
      chk("below_fault", {31'b0, fault}, 32'd1);

      // Reset in the middle of a load keeps BRAM contents
      load_start = 1'b1; step(); load_start = 1'b0;
      reset_n = 1'b0; step(); reset_n = 1'b1;
      chk("mrst_stall", {31'b0, stall}, 32'd1);
      chk("mrst_instr", instr, 32'h0);
      chk("mrst_fault", {31'b0, fault}, 32'd0);
      load_start = 1'b1; step(); load_start = 1'b0;
      load_end = 1'b1; step(); load_end = 1'b0;
      chk("mrst_count", {16'b0, loaded_words}, 32'd0);
      fetch(32'h8000_0004);
      chk("retain_w1", instr, 32'h0020_0113);
      fetch(32'h8000_0000);
      chk("retain_w0", instr, 32'h0010_CC93);
      chk("retain_oe", {31'b0, rom_oe}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder for the rv32i core's fetch port. It owns the program BRAM, accepts a program image written word-by-word from the host/bridge side, and then serves the core's `rom_addr`/`rom_re` requests with `instr`/`rom_oe` at one-cycle latency. While a program is being loaded it holds the core in reset and stalled. It sits between the bridge write path and `rv32i_top` in the core wrapper.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: program memory size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h8000_0000: byte address mapped to word 0 for both loads and fetches.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `load_start` in 1: pulse; begin or restart a program load.
- `load_end` in 1: pulse; image complete, release core.
- `load_we` in 1: write strobe for one word.
- `load_addr` in 32: byte address of the write; `BASE_ADDR`-relative, word-aligned.
- `load_data` in 32: write data.
- `load_be` in 4: byte enables; bit i writes `load_data[8i+7:8i]`.
- `rom_addr` in 32: fetch byte address from the core.
- `rom_re` in 1: fetch request.
- `instr` out 32: fetched instruction.
- `rom_oe` out 1: `instr` valid this cycle.
- `stall` out 1: freeze core PC.
- `core_reset_n` out 1: active-low reset to the core.
- `loaded_words` out 16: count of accepted load writes, saturating at 16'hFFFF.
- `fault` out 1: sticky; a fetch was out of range or misaligned.

## Operation
- States: `IMEM_IDLE`, `IMEM_LOAD`, `IMEM_RUN`.
- `IMEM_IDLE` is entered on reset. `load_start` moves it to `IMEM_LOAD`. Fetches are ignored.
- In `IMEM_LOAD`:
  - `load_start` clears `loaded_words` and `fault` and stays in `IMEM_LOAD`.
  - `load_end` moves to `IMEM_RUN`.
  - If `load_start` and `load_end` arrive together, `load_start` wins.
- In `IMEM_RUN`, `load_start` returns to `IMEM_LOAD`. This reloads mid-run, and the core is put back into reset on the next edge.
- Writes:
  - A write is accepted only in `IMEM_LOAD` with `load_we=1` and an in-range word-aligned address.
  - Each accepted write increments `loaded_words`.
  - A write coincident with `load_end` is committed.
  - A write outside `IMEM_LOAD`, a misaligned write (`load_addr[1:0]!=0`) or an out-of-range write is dropped and not counted.
- Fetch:
  - A fetch happens in `IMEM_RUN` when `rom_re=1`.
  - Word index is `(rom_addr-BASE_ADDR)>>2`, computed modulo 2^32.
  - The address is in range iff the index is below `DEPTH_WORDS` and `rom_addr[1:0]==0`.
  - An out-of-range or misaligned fetch returns `RV32I_NOP` (32'h0000_0013) and sets `fault`.
- `core_reset_n = (state==IMEM_RUN)`. `stall = (state!=IMEM_RUN)`. Both are registered.

## Timing
- Reset values:
  - state `IMEM_IDLE`
  - `instr=32'h0`
  - `rom_oe=0`
  - `stall=1`
  - `core_reset_n=0`
  - `loaded_words=0`
  - `fault=0`
- Fetch latency is 1 cycle. `rom_addr` is sampled at edge N; `instr` and `rom_oe=1` are valid after edge N. This matches the core presenting `next_pc` and latching `instr` for `pc`.
- With `rom_re=0` or outside `IMEM_RUN`, `rom_oe=0` and `instr` holds its last value.
- Load-write-to-fetch: the earliest fetch is in the cycle after the `IMEM_RUN` transition, so no read-during-write hazard exists. The BRAM may be read-first or write-first.
- `load_end` at edge N: `core_reset_n=1` and `stall=0` are visible after edge N.
- `load_start` in `IMEM_RUN` at edge N: `core_reset_n=0`, `stall=1` and `rom_oe=0` after edge N.
- Reset mid-load: BRAM contents are retained, and the block returns to `IMEM_IDLE`.

## Structure
- Add to the shared `rv32i` package:
  - `imem_state_e` (`IMEM_IDLE`, `IMEM_LOAD`, `IMEM_RUN`)
  - `localparam RV32I_NOP = 32'h0000_0013`
- Sub-module `imem_bram`: a true dual-address single-clock BRAM with one write port with byte enables and one registered read port, sized by `DEPTH_WORDS`. It must infer block RAM.
- FSM, range checks, counter and output registers live in `imem_server`.

## Test plan
- Reset, then `load_start` and 3 writes at 0x8000_0000/4/8 of 0x00100093, 0x00200113, 0x002081B3, then `load_end` -> `loaded_words=3`, and `stall=0` and `core_reset_n=1` one edge after `load_end`.
- After that load, drive `rom_addr` 0x8000_0004 with `rom_re=1` -> next cycle `instr=0x00200113`, `rom_oe=1`, `fault=0`.
- Fetch 0x8000_4000 (DEPTH 4096) and 0x8000_0002 -> `instr=0x00000013` each, `fault=1` (sticky).
- In `IMEM_LOAD`, write `load_be=4'b0010`, data 0xAABBCCDD, to word 0 holding 0x00100093 -> a later fetch reads 0x0010CC93.
- In `IMEM_RUN`, assert `load_start` and `load_end` together -> state `IMEM_LOAD`, `stall=1`, `core_reset_n=0`, `loaded_words=0`, `fault=0`.
- Write at 0x8000_0000 outside `IMEM_LOAD`, and a write at 0x7FFF_FFFC -> memory unchanged, `loaded_words` unchanged.
